// File: rtl/psram_if_responder.sv
// psram_if_responder: BSRAM-backed stand-in for the PSRAM memory-interface user port.
// Latency: read beat k valid READ_LAT+k cycles after acceptance; write beat k sampled k cycles after acceptance.
// Backpressure: none; commands arriving before calibration or while busy are dropped and flagged on sticky cmd_err.
//
// Ports:
//   clk_logic, reset      - user clock (rising edge), asynchronous active-high reset
//   cmd, cmd_en, addr     - command strobe (1 = write, 0 = read) and burst base word index
//   wr_data, data_mask    - write beat data; mask bit = 1 leaves that byte untouched
//   rd_data, rd_data_valid- read beat data (holds last beat when not valid) and its qualifier
//   init_calib            - high once the calibration delay has elapsed
//   cmd_err               - sticky flag: a command was dropped
//   busy                  - high from acceptance until the next command may be accepted
module psram_if_responder #(
  parameter int ADDR_W       = 21,
  parameter int MEM_AW       = 10,
  parameter int BURST        = 4,
  parameter int READ_LAT     = 6,
  parameter int CMD_GAP      = 14,
  parameter int CALIB_CYCLES = 64
) (
  input  logic              clk_logic,
  input  logic              reset,
  input  logic              cmd,
  input  logic              cmd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wr_data,
  input  logic [7:0]        data_mask,
  output logic [63:0]       rd_data,
  output logic              rd_data_valid,
  output logic              init_calib,
  output logic              cmd_err,
  output logic              busy
);

  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int GW = $clog2(CMD_GAP + 1);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [2:0] {CALIB, IDLE, WRITE, RD_WAIT, RD_DATA, GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     calib_cnt_q, calib_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic              init_calib_q, init_calib_d;
  logic              cmd_err_q, cmd_err_d;
  logic              busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic [63:0]       rd_data_q;

  logic              can_accept;
  logic              mem_we;
  logic              mem_re;
  logic [MEM_AW-1:0] beat_addr;
  logic [MEM_AW-1:0] mem_waddr;
  logic [63:0]       mem [0:(1<<MEM_AW)-1];

  // Address bits above the backing depth are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_W-1:MEM_AW];

  // Wraps naturally modulo the backing depth.
  assign beat_addr = base_q + MEM_AW'(beat_q);

  always_comb begin
    state_d      = state_q;
    calib_cnt_d  = calib_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    beat_d       = beat_q;
    base_d       = base_q;
    init_calib_d = init_calib_q;
    cmd_err_d    = cmd_err_q;
    busy_d       = busy_q;
    rd_valid_d   = 1'b0;
    can_accept   = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_waddr    = beat_addr;

    case (state_q)
      CALIB: begin
        calib_cnt_d = calib_cnt_q + 1'b1;
        if (calib_cnt_q == CW'(CALIB_CYCLES - 1)) begin
          init_calib_d = 1'b1;
          state_d      = IDLE;
        end
      end
      IDLE: can_accept = 1'b1;
      WRITE: begin
        mem_we    = 1'b1;
        beat_d    = beat_q + 1'b1;
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (beat_q == BW'(BURST - 1)) state_d = GAP;
      end
      RD_WAIT: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        // One cycle early: the synchronous read lands on the READ_LAT edge.
        if (gap_cnt_q == GW'(READ_LAT - 1)) state_d = RD_DATA;
      end
      RD_DATA: begin
        mem_re     = 1'b1;
        rd_valid_d = 1'b1;
        beat_d     = beat_q + 1'b1;
        gap_cnt_d  = gap_cnt_q + 1'b1;
        if (beat_q == BW'(BURST - 1)) state_d = GAP;
      end
      GAP: begin
        // The edge that completes the gap already accepts a new command.
        if (gap_cnt_q == GW'(CMD_GAP)) begin
          can_accept = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = CALIB;
    endcase

    if (cmd_en) begin
      if (can_accept) begin
        base_d    = addr[MEM_AW-1:0];
        busy_d    = 1'b1;
        gap_cnt_d = GW'(1);
        if (cmd) begin
          // Beat 0 is written on the accepting edge itself.
          mem_we    = 1'b1;
          mem_waddr = addr[MEM_AW-1:0];
          beat_d    = BW'(1);
          state_d   = WRITE;
        end else begin
          beat_d  = '0;
          state_d = RD_WAIT;
        end
      end else begin
        cmd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      state_q      <= CALIB;
      calib_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      beat_q       <= '0;
      base_q       <= '0;
      init_calib_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      calib_cnt_q  <= calib_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      init_calib_q <= init_calib_d;
      cmd_err_q    <= cmd_err_d;
      busy_q       <= busy_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Backing store: byte-enable writes, never reset.
  always_ff @(posedge clk_logic) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (!data_mask[i]) mem[mem_waddr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Synchronous read port; holds the last beat between bursts.
  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (mem_re) begin
      rd_data_q <= mem[beat_addr];
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign init_calib    = init_calib_q;
  assign cmd_err       = cmd_err_q;
  assign busy          = busy_q;

endmodule
